// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: merges pipeline writebacks with buffered MDU results,
// enforces a starvation bound on the MDU FIFO and tracks outstanding MDU destinations.
module writeback_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wb_valid,
    input  logic [4:0]  pipe_wb_rd,
    input  logic [31:0] pipe_wb_data,
    output logic        pipe_stall,
    input  logic        mdu_issue_valid,
    input  logic [4:0]  mdu_issue_rd,
    input  logic        mdu_res_valid,
    input  logic [4:0]  mdu_res_rd,
    input  logic [31:0] mdu_res_data,
    output logic        mdu_res_ready,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rf_wr_en,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_rd_value
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [36:0]    mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_reg;
    logic [PTR_W:0] rd_ptr_reg;
    logic           fifo_empty;
    logic           fifo_full;
    logic [36:0]    head;
    logic [4:0]     head_rd;
    logic [31:0]    head_data;

    logic           take_pipe;
    logic           pop;
    logic           push;

    logic [3:0]     starve_cnt_reg;
    logic [3:0]     starve_cnt_inc;
    logic           stall_reg;

    logic [31:0]    busy_reg;
    logic [31:0]    busy_next;

    logic           wr_en_reg;
    logic [4:0]     wr_rd_reg;
    logic [31:0]    wr_value_reg;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]) &&
                        (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]);

    assign head      = mem[rd_ptr_reg[PTR_W-1:0]];
    assign head_rd   = head[36:32];
    assign head_data = head[31:0];

    // Ready looks only at full, so a same-cycle pop never opens a slot early.
    assign mdu_res_ready = !fifo_full && !rst;
    assign push          = mdu_res_valid && !fifo_full && (mdu_res_rd != 5'd0);

    assign take_pipe = !stall_reg && pipe_wb_valid && (pipe_wb_rd != 5'd0);
    assign pop       = !take_pipe && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= {mdu_res_rd, mdu_res_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    assign starve_cnt_inc = starve_cnt_reg + 4'd1;

    // Each pipeline write that blocks a waiting MDU result counts toward a forced bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= 4'd0;
            stall_reg      <= 1'b0;
        end else if (take_pipe && !fifo_empty) begin
            if (starve_cnt_inc == LIMIT) begin
                starve_cnt_reg <= 4'd0;
                stall_reg      <= 1'b1;
            end else begin
                starve_cnt_reg <= starve_cnt_inc;
                stall_reg      <= 1'b0;
            end
        end else begin
            starve_cnt_reg <= 4'd0;
            stall_reg      <= 1'b0;
        end
    end

    // A new issue to r wins over the retirement of an older r in the same edge.
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign busy_next[gi] = 1'b0;
        end else begin : g_bit
            assign busy_next[gi] = (mdu_issue_valid && (mdu_issue_rd == 5'(gi))) ||
                                   (busy_reg[gi] && !(pop && (head_rd == 5'(gi))));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign rs1_busy = busy_reg[rs1_addr] && (rs1_addr != 5'd0);
    assign rs2_busy = busy_reg[rs2_addr] && (rs2_addr != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_reg    <= 1'b0;
            wr_rd_reg    <= 5'd0;
            wr_value_reg <= 32'd0;
        end else if (take_pipe) begin
            wr_en_reg    <= 1'b1;
            wr_rd_reg    <= pipe_wb_rd;
            wr_value_reg <= pipe_wb_data;
        end else if (pop) begin
            wr_en_reg    <= 1'b1;
            wr_rd_reg    <= head_rd;
            wr_value_reg <= head_data;
        end else begin
            wr_en_reg    <= 1'b0;
        end
    end

    assign rf_wr_en    = wr_en_reg;
    assign rf_rd       = wr_rd_reg;
    assign rf_rd_value = wr_value_reg;
    assign pipe_stall  = stall_reg;

endmodule
